// File: rtl/adc_pkg.sv
// adc_pkg: definitions shared by the ADC conversion sequencer and its
// interface.
//   state_t      - sequencer state encoding.
//   OSR_MAX_LOG2 - upper clamp on log2(conversions per sequence).
//   RESULT_W     - width of the oversampled result.
//   REMAIN_W     - width of the per-sequence conversion counter.
//   osr_count()  - turns the requested OSR into a conversion count.
package adc_pkg;

  localparam int OSR_MAX_LOG2 = 5;
  localparam int RESULT_W     = 16;
  // Wide enough to hold 2^OSR_MAX_LOG2.
  localparam int REMAIN_W     = 6;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    WAIT_DONE,
    GAP,
    WAIT_RESULT,
    ABORT,
    FINISH
  } state_t;

  // Conversions per sequence: 2^min(osr, OSR_MAX_LOG2).
  function automatic logic [REMAIN_W-1:0] osr_count(input logic [2:0] osr);
    logic [2:0] n;
    n = (osr > 3'(OSR_MAX_LOG2)) ? 3'(OSR_MAX_LOG2) : osr;
    return REMAIN_W'(1) << n;
  endfunction

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// adc_conv_sequencer_if: groups the host start/config/status signals and the
// datapath handshake signals of the conversion sequencer.
//   slave  - the sequencer side (receives requests and datapath events).
//   master - the host/datapath side (issues requests, observes status).
// Signals:
//   start_conversion_in, osr_mode_in[2:0], continuous_in    host -> sequencer
//   conv_done_in, result_valid_in, result_in[15:0]          datapath -> sequencer
//   ena_loop_out, start_conv_out                            sequencer -> datapath
//   busy_out, conversion_finished_out, result_out[15:0],
//   timeout_out                                             sequencer -> host
interface adc_conv_sequencer_if;
  import adc_pkg::*;

  logic                start_conversion_in;
  logic [2:0]          osr_mode_in;
  logic                continuous_in;
  logic                conv_done_in;
  logic                result_valid_in;
  logic [RESULT_W-1:0] result_in;

  logic                ena_loop_out;
  logic                start_conv_out;
  logic                busy_out;
  logic                conversion_finished_out;
  logic [RESULT_W-1:0] result_out;
  logic                timeout_out;

  modport slave (
    input  start_conversion_in, osr_mode_in, continuous_in,
    input  conv_done_in, result_valid_in, result_in,
    output ena_loop_out, start_conv_out, busy_out,
    output conversion_finished_out, result_out, timeout_out
  );

  modport master (
    output start_conversion_in, osr_mode_in, continuous_in,
    output conv_done_in, result_valid_in, result_in,
    input  ena_loop_out, start_conv_out, busy_out,
    input  conversion_finished_out, result_out, timeout_out
  );

endinterface

// File: rtl/adc_seq_watchdog.sv
// adc_seq_watchdog: up-counter used to bound the time spent waiting on the
// datapath. Clearing loads zero; the counter advances only while enabled.
//   clk, nrst  - clock, asynchronous active-low reset.
//   clr        - load zero (takes priority over en).
//   en         - count this cycle.
//   expired    - high while enabled and the count sits on LIMIT-1, i.e. in
//                the LIMIT-th enabled cycle after a clear.
module adc_seq_watchdog #(
  parameter int LIMIT = 64,
  parameter int W     = 7
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = en && (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: turns one host start request into 2^N back-to-back SAR
// conversions, gates the clock-loop enable around them, watchdogs every
// conversion and the final filter result, and reports completion to the host.
// Ports:
//   clk   - system clock.
//   nrst  - asynchronous active-low reset; aborts any sequence silently.
//   io    - adc_conv_sequencer_if.slave (host request/status + datapath
//           handshake, see the interface file).
// Parameters:
//   TIMEOUT_CYCLES - max cycles waited for conv_done / result_valid.
//   TIMEOUT_W      - watchdog width, 2^TIMEOUT_W > TIMEOUT_CYCLES.
//   GAP_CYCLES     - idle cycles between conversions (0 allowed).
// Build option:
//   ADC_SEQ_CONTINUOUS_EN - when defined, a sequence that finishes cleanly
//   while continuous_in is high immediately starts the next one.
module adc_conv_sequencer
  import adc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_W      = 7,
  parameter int GAP_CYCLES     = 2
) (
  input logic                clk,
  input logic                nrst,
  adc_conv_sequencer_if.slave io
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t              state_reg;
  logic                start_q_reg;
  logic [REMAIN_W-1:0] remaining_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;

  logic start_edge;
  logic restart;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  assign start_edge = io.start_conversion_in && !start_q_reg;

  // One watchdog serves both wait states: zeroed at launch and again on the
  // final conv_done so WAIT_RESULT gets a full window of its own.
  assign wd_en  = (state_reg == WAIT_DONE) || (state_reg == WAIT_RESULT);
  assign wd_clr = (state_reg == LAUNCH) || ((state_reg == WAIT_DONE) && io.conv_done_in);

  adc_seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

`ifdef ADC_SEQ_CONTINUOUS_EN
  // timeout_out is already set when FINISH follows ABORT, so an aborted
  // sequence never chains into another one.
  assign restart = io.continuous_in && !io.timeout_out;
`else
  assign restart = 1'b0;
  logic unused_continuous;
  assign unused_continuous = io.continuous_in;
`endif

  // Outputs are registered alongside the state: each transition also sets
  // the output values that belong to the state being entered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg                  <= IDLE;
      start_q_reg                <= 1'b0;
      remaining_reg              <= '0;
      gap_cnt_reg                <= '0;
      io.ena_loop_out            <= 1'b0;
      io.start_conv_out          <= 1'b0;
      io.busy_out                <= 1'b0;
      io.conversion_finished_out <= 1'b0;
      io.result_out              <= '0;
      io.timeout_out             <= 1'b0;
    end else begin
      start_q_reg                <= io.start_conversion_in;
      io.start_conv_out          <= 1'b0;
      io.conversion_finished_out <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            remaining_reg   <= osr_count(io.osr_mode_in);
            io.timeout_out  <= 1'b0;
            io.ena_loop_out <= 1'b1;
            io.busy_out     <= 1'b1;
            state_reg       <= ARM;
          end
        end
        ARM: begin
          io.start_conv_out <= 1'b1;
          state_reg         <= LAUNCH;
        end
        LAUNCH: begin
          state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done in the expiry cycle wins over the timeout.
          if (io.conv_done_in) begin
            remaining_reg <= remaining_reg - REMAIN_W'(1);
            if (remaining_reg == REMAIN_W'(1)) begin
              io.ena_loop_out <= 1'b0;
              state_reg       <= WAIT_RESULT;
            end else if (GAP_CYCLES == 0) begin
              io.start_conv_out <= 1'b1;
              state_reg         <= LAUNCH;
            end else begin
              gap_cnt_reg <= '0;
              state_reg   <= GAP;
            end
          end else if (wd_expired) begin
            io.ena_loop_out <= 1'b0;
            state_reg       <= ABORT;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            io.start_conv_out <= 1'b1;
            state_reg         <= LAUNCH;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        WAIT_RESULT: begin
          if (io.result_valid_in) begin
            io.result_out              <= io.result_in;
            io.conversion_finished_out <= 1'b1;
            state_reg                  <= FINISH;
          end else if (wd_expired) begin
            state_reg <= ABORT;
          end
        end
        ABORT: begin
          io.timeout_out             <= 1'b1;
          io.conversion_finished_out <= 1'b1;
          state_reg                  <= FINISH;
        end
        FINISH: begin
          if (restart) begin
            remaining_reg   <= osr_count(io.osr_mode_in);
            io.ena_loop_out <= 1'b1;
            state_reg       <= ARM;
          end else begin
            io.busy_out <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb_adc_conv_sequencer: directed-vector bench for adc_conv_sequencer.
// The stimulus process pushes the hand-computed outcome of every sequence
// into a queue; a monitor pops it on each conversion_finished_out pulse.
// A responder process plays the SAR control / filter side.
module tb_adc_conv_sequencer;
  import adc_pkg::*;

  typedef struct {
    logic [15:0] result;
    logic        timeout;
    int          launches;
    int          lat;        // cycles from last start_conv_out to finished
    int          start_cyc;  // cycle the start edge was presented, -1 if none
  } exp_t;

  logic clk;
  logic nrst;
  adc_conv_sequencer_if bus();

  adc_conv_sequencer #(
    .TIMEOUT_CYCLES (64),
    .TIMEOUT_W      (7),
    .GAP_CYCLES     (2)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .io   (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done_cyc = -100;
  int   n_finished = 0;

  // Responder configuration, set by the stimulus before each start.
  int          cfg_done_delay = 1;  // 0: never answer (forces a timeout)
  int          cfg_res_delay  = 1;
  int          cfg_convs      = 1;
  int          cfg_stray      = 0;  // stray result_valid N cycles after launch
  logic [15:0] cfg_res_value  = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Cycle counter plus conv_done timestamps, sampled at the active edge
  // where the bench-driven inputs are stable.
  initial begin
    forever begin
      @(posedge clk);
      if (bus.conv_done_in) last_done_cyc = cyc;
      cyc++;
    end
  end

  // Datapath model: answers each launch with conv_done after
  // cfg_done_delay cycles and, after the last conversion, result_valid.
  initial begin
    int   cd;
    int   rcd;
    int   ndone;
    logic stray;
    cd = 0; rcd = 0; ndone = 0; stray = 1'b0;
    bus.conv_done_in    = 1'b0;
    bus.result_valid_in = 1'b0;
    bus.result_in       = '0;
    forever begin
      @(negedge clk);
      bus.conv_done_in    = 1'b0;
      bus.result_valid_in = 1'b0;
      if (!bus.busy_out) begin
        cd = 0; rcd = 0; ndone = 0; stray = 1'b0;
      end else begin
        if (rcd > 0) begin
          rcd--;
          if (rcd == 0) begin
            bus.result_valid_in = 1'b1;
            bus.result_in       = stray ? 16'hDEAD : cfg_res_value;
            stray = 1'b0;
          end
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.conv_done_in = 1'b1;
            ndone++;
            if (ndone == cfg_convs) begin
              ndone = 0;
              rcd   = cfg_res_delay;
            end
          end
        end
        if (bus.start_conv_out) begin
          if (cfg_done_delay > 0) begin
            cd = cfg_done_delay;
          end else if (cfg_stray > 0) begin
            rcd   = cfg_stray;
            stray = 1'b1;
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    int   seq_launches;
    int   ena_rises;
    int   last_launch;
    logic ena_prev;
    seq_launches = 0; ena_rises = 0; last_launch = 0; ena_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.busy_out) begin
        seq_launches = 0;
        ena_rises    = 0;
      end
      if (bus.ena_loop_out && !ena_prev) ena_rises++;
      ena_prev = bus.ena_loop_out;
      if (bus.start_conv_out) begin
        chk("ena_at_launch", int'(bus.ena_loop_out), 1);
        if (seq_launches == 0) begin
          chk("timeout_cleared", int'(bus.timeout_out), 0);
          if (exp_q.size() > 0 && exp_q[0].start_cyc >= 0)
            chk("start_latency", cyc - exp_q[0].start_cyc, 2);
        end else begin
          chk("gap_spacing", cyc - last_done_cyc, 3);
        end
        seq_launches++;
        last_launch = cyc;
      end
      if (bus.conversion_finished_out) begin
        n_finished++;
        chk("finish_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("txn %0d: result=%04h timeout=%0d launches=%0d latency=%0d",
                   n_finished, bus.result_out, bus.timeout_out, seq_launches, cyc - last_launch);
          chk("result", int'(bus.result_out), int'(e.result));
          chk("timeout", int'(bus.timeout_out), int'(e.timeout));
          chk("launch_count", seq_launches, e.launches);
          chk("finish_latency", cyc - last_launch, e.lat);
          chk("ena_single_window", ena_rises, 1);
          chk("ena_low_at_finish", int'(bus.ena_loop_out), 0);
          chk("busy_at_finish", int'(bus.busy_out), 1);
        end
        seq_launches = 0;
        ena_rises    = 0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (bus.busy_out && i < budget);
    chk("idle_reached", int'(bus.busy_out), 0);
  endtask

  task automatic run_seq(input logic [2:0] osr, input int dd, input int rd,
                         input logic [15:0] val, input int stray,
                         input logic [15:0] exp_res, input logic exp_to,
                         input int exp_launches, input int exp_lat, input logic glitch);
    @(negedge clk);
    cfg_done_delay = dd;
    cfg_res_delay  = rd;
    cfg_res_value  = val;
    cfg_convs      = exp_launches;
    cfg_stray      = stray;
    bus.osr_mode_in         = osr;
    bus.start_conversion_in = 1'b1;
    exp_q.push_back('{result: exp_res, timeout: exp_to, launches: exp_launches,
                      lat: exp_lat, start_cyc: cyc});
    repeat (2) @(negedge clk);
    bus.start_conversion_in = 1'b0;
    bus.osr_mode_in         = ~osr;  // must not affect the running sequence
    if (glitch) begin
      repeat (4) @(negedge clk);
      bus.start_conversion_in = 1'b1;
      repeat (2) @(negedge clk);
      bus.start_conversion_in = 1'b0;
    end
    wait_idle(4000);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    nrst = 1'b0;
    bus.start_conversion_in = 1'b0;
    bus.osr_mode_in         = 3'd0;
    bus.continuous_in       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ena", int'(bus.ena_loop_out), 0);
    chk("rst_start_conv", int'(bus.start_conv_out), 0);
    chk("rst_busy", int'(bus.busy_out), 0);
    chk("rst_finished", int'(bus.conversion_finished_out), 0);
    chk("rst_result", int'(bus.result_out), 0);
    chk("rst_timeout", int'(bus.timeout_out), 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // osr, done_dly, res_dly, value, stray, exp result, exp timeout, launches, latency, glitch
    run_seq(3'd0, 10, 3, 16'h1234, 0, 16'h1234, 1'b0,  1, 14, 1'b0);  // single shot
    run_seq(3'd3,  4, 2, 16'hABCD, 0, 16'hABCD, 1'b0,  8,  7, 1'b1);  // 8x, start edge while busy
    run_seq(3'd7,  2, 1, 16'h0F0F, 0, 16'h0F0F, 1'b0, 32,  4, 1'b0);  // clamp to 32
    run_seq(3'd0,  0, 1, 16'h9999, 5, 16'h0F0F, 1'b1,  1, 66, 1'b0);  // timeout, stray result ignored
    run_seq(3'd0, 64, 1, 16'h4321, 0, 16'h4321, 1'b0,  1, 66, 1'b0);  // done in expiry cycle

    // Reset while waiting for conv_done: outputs clear at once, no finish.
    @(negedge clk);
    cfg_done_delay = 10; cfg_res_delay = 2; cfg_convs = 8; cfg_stray = 0;
    bus.osr_mode_in = 3'd3;
    bus.start_conversion_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_conversion_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", int'(bus.busy_out), 1);
    nrst = 1'b0;
    #1;
    chk("arst_ena", int'(bus.ena_loop_out), 0);
    chk("arst_busy", int'(bus.busy_out), 0);
    chk("arst_result", int'(bus.result_out), 0);
    chk("arst_timeout", int'(bus.timeout_out), 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", int'(bus.busy_out), 0);

    run_seq(3'd0, 3, 2, 16'h5A5A, 0, 16'h5A5A, 1'b0, 1, 6, 1'b0);

    // Continuous mode: two conversions per sequence.
    @(negedge clk);
    cfg_done_delay = 3; cfg_res_delay = 2; cfg_convs = 2; cfg_stray = 0;
    cfg_res_value = 16'h0C0C;
    bus.osr_mode_in   = 3'd1;
    bus.continuous_in = 1'b1;
    base = n_finished;
    bus.start_conversion_in = 1'b1;
    exp_q.push_back('{result: 16'h0C0C, timeout: 1'b0, launches: 2, lat: 6, start_cyc: cyc});
`ifdef ADC_SEQ_CONTINUOUS_EN
    exp_q.push_back('{result: 16'h0C0C, timeout: 1'b0, launches: 2, lat: 6, start_cyc: -1});
    exp_q.push_back('{result: 16'h0C0C, timeout: 1'b0, launches: 2, lat: 6, start_cyc: -1});
`endif
    repeat (2) @(negedge clk);
    bus.start_conversion_in = 1'b0;
`ifdef ADC_SEQ_CONTINUOUS_EN
    for (int i = 0; i < 500 && (n_finished - base) < 2; i++) @(negedge clk);
    chk("continuous_progress", int'((n_finished - base) >= 2), 1);
    bus.continuous_in = 1'b0;
    wait_idle(500);
    chk("continuous_count", n_finished - base, 3);
`else
    wait_idle(500);
    repeat (10) @(negedge clk);
    chk("continuous_ignored", n_finished - base, 1);
    bus.continuous_in = 1'b0;
`endif
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
- Top-level conversion scheduler between the host config/start interface and the ADC datapath (nonbinary SAR control, clock loop, oversampling filter).
- Converts one external start request into 2^N back-to-back SAR conversions and gates the clock loop enable.
- Watchdogs each conversion and captures the final oversampled result with a single finished pulse to the host.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles from start_conv_out pulse to conv_done_in before abort.
- TIMEOUT_W, 7: watchdog counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.
- GAP_CYCLES, 2: idle cycles between consecutive conversions (ena_loop_out stays high); 0 is legal.
- OSR_MAX_LOG2, 5: clamp for osr_mode_in; maximum 32 conversions.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- start_conversion_in  in  1  level request; already synchronous to clk; rising edge starts a sequence.
- osr_mode_in  in  3  log2 of conversions per sequence; latched on accepted start.
- continuous_in  in  1  repeat sequences while high; used only with ADC_SEQ_CONTINUOUS_EN.
- conv_done_in  in  1  one-cycle pulse per completed SAR conversion from the nonbinary control.
- result_valid_in  in  1  one-cycle pulse from the oversampling filter; result_in is valid.
- result_in  in  16  oversampled result.
- ena_loop_out  out  1  clock-loop enable.
- start_conv_out  out  1  one-cycle pulse that launches one conversion.
- busy_out  out  1  high in every state except IDLE.
- conversion_finished_out  out  1  one-cycle completion pulse.
- result_out  out  16  captured result; holds its value between captures.
- timeout_out  out  1  sticky abort flag.

Behaviour:
- Reset (async, nrst=0): state=IDLE; all outputs 0, including result_out=0 and timeout_out=0; all counters 0. Reset mid-sequence aborts immediately with no finished pulse.
- Edge detect: start_q register. Accept when start_conversion_in=1, start_q=0 and state=IDLE. Edges in any other state are ignored; they are not queued.
- On accept:
  - Latch n = min(osr_mode_in, OSR_MAX_LOG2).
  - Load remaining = 2^n (6-bit counter).
  - Clear timeout_out.
  - Go to ARM.
- ARM: ena_loop_out=1 (held through the last WAIT_DONE); next cycle → LAUNCH.
- LAUNCH: start_conv_out=1 for exactly this cycle; watchdog cleared to 0; → WAIT_DONE.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - On conv_done_in: decrement remaining. If remaining becomes 0 → WAIT_RESULT with ena_loop_out=0 from the next cycle; otherwise → GAP.
  - If watchdog reaches TIMEOUT_CYCLES-1 without conv_done_in → ABORT.
  - conv_done_in in the same cycle as expiry counts as done; no timeout.
  - conv_done_in outside WAIT_DONE is ignored.
- GAP: waits GAP_CYCLES cycles, then → LAUNCH. With GAP_CYCLES=0, go directly WAIT_DONE → LAUNCH.
- WAIT_RESULT:
  - Watchdog restarts from 0.
  - On result_valid_in: result_out <= result_in → FINISH.
  - On expiry → ABORT.
  - result_valid_in outside WAIT_RESULT is ignored; result_out is unchanged.
- ABORT: timeout_out <= 1; ena_loop_out=0; → FINISH; result_out unchanged.
- FINISH: conversion_finished_out=1 for one cycle → IDLE.
- Latency: a start edge sampled at cycle t gives ARM at t+1 and start_conv_out at t+2.
- osr_mode_in changes after accept have no effect on the running sequence.

Optional Feature:
- Macro: ADC_SEQ_CONTINUOUS_EN.
- With the macro: in FINISH, if continuous_in=1 and no abort occurred, relatch osr_mode_in, reload remaining and go to ARM instead of IDLE. busy_out stays high. conversion_finished_out still pulses once per sequence. Dropping continuous_in lets the current sequence complete and then return to IDLE.
- Without the macro: continuous_in is ignored and FINISH always goes to IDLE.

Decomposition:
- Shared package adc_pkg:
  - state encoding constants: IDLE, ARM, LAUNCH, WAIT_DONE, GAP, WAIT_RESULT, ABORT, FINISH;
  - OSR_MAX_LOG2;
  - 16-bit result width constant.
- Natural sub-module: adc_seq_watchdog, a loadable up-counter with clear/enable and expire output. It is reused for WAIT_DONE and WAIT_RESULT.

Test Plan:
- Single shot: osr_mode_in=0; start edge; conv_done_in 10 cycles after start_conv_out; result_valid_in=1 with result_in=16'h1234 three cycles later.
  → exactly one start_conv_out pulse; result_out=16'h1234; conversion_finished_out one cycle; timeout_out=0.
- Oversampling: osr_mode_in=3, GAP_CYCLES=2.
  → 8 start_conv_out pulses, each 3 cycles after the preceding conv_done_in; ena_loop_out high continuously from ARM until the 8th done.
- Clamp: osr_mode_in=7.
  → exactly 32 start_conv_out pulses.
- Timeout: no conv_done_in after the first launch.
  → ABORT after 64 cycles; timeout_out=1; finished pulse; result_out keeps its previous value. Next accepted start clears timeout_out.
- Boundary: conv_done_in in the exact expiry cycle.
  → no abort. Start edge while busy → ignored, pulse count unchanged.
- Reset mid-WAIT_DONE: nrst low for one cycle.
  → all outputs 0 asynchronously; no finished pulse. A new start works normally; with ADC_SEQ_CONTINUOUS_EN and continuous_in=1, three consecutive finished pulses appear without re-start.
